nios_cpu_mem_bist_master: RTL

Avalon-MM initiator that drives the on-chip memory slave port (s1) of the Nios CPU subsystem to fill and read-back-verify address ranges. It sits beside the CPU on the memory interconnect and is used at boot and from the LMX2694 control firmware to initialise and test the 32768 x 32-bit on-chip RAM. It issues one access per cycle and compares pipelined read data against a regenerated pattern. It reports completion, error count and first failing address.

---
 rtl/nios_cpu_mem_bist_pkg.sv | 17 +
 rtl/nios_cpu_mem_bist_master_if.sv | 19 +
 rtl/nios_cpu_mem_bist_patgen.sv | 23 ++
 rtl/nios_cpu_mem_bist_master.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/nios_cpu_mem_bist_pkg.sv
// nios_cpu_mem_bist_pkg: shared widths, limits, op/state types and LFSR polynomial for the RAM BIST master
package nios_cpu_mem_bist_pkg;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int MAX_WORDS = 32768;
    localparam logic [DATA_W-1:0] LFSR_POLY = 32'h8020_0003;
    typedef enum logic {
        OP_FILL  = 1'b0,
        OP_CHECK = 1'b1
    } op_t;
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;
endpackage

// File: rtl/nios_cpu_mem_bist_master_if.sv
// nios_cpu_mem_bist_master_if: Avalon-MM bus between the BIST master and the on-chip RAM s1 port
interface nios_cpu_mem_bist_master_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] m_address;
    logic [3:0]        m_byteenable;
    logic              m_chipselect;
    logic              m_write;
    logic [31:0]       m_writedata;
    logic [31:0]       m_readdata;
    modport master (
        output m_address, m_byteenable, m_chipselect, m_write, m_writedata,
        input  m_readdata
    );
    modport slave (
        input  m_address, m_byteenable, m_chipselect, m_write, m_writedata,
        output m_readdata
    );
endinterface

// File: rtl/nios_cpu_mem_bist_patgen.sv
// nios_cpu_mem_bist_patgen: word pattern source; NIOS_CPU_MEM_BIST_LFSR_EN selects Galois LFSR, else seed + i
module nios_cpu_mem_bist_patgen
    import nios_cpu_mem_bist_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] value,
    output logic [DATA_W-1:0] nxt
);
`ifdef NIOS_CPU_MEM_BIST_LFSR_EN
    // An all-zero LFSR would lock up, so a zero seed starts at 1
    always_comb nxt = load ? ((seed == '0) ? 32'd1 : seed)
                    : step ? ((value >> 1) ^ (value[0] ? LFSR_POLY : '0)) : value;
`else
    // Incrementing pattern, wrapping at 32 bits
    always_comb nxt = load ? seed : step ? value + 32'd1 : value;
`endif
    // Current pattern word, aligned with the access on the bus
    always_ff @(posedge clk) value <= reset ? '0 : nxt;
endmodule

// File: rtl/nios_cpu_mem_bist_master.sv
// nios_cpu_mem_bist_master: Avalon-MM fill / read-back-verify engine for the on-chip RAM
// Pattern selected by NIOS_CPU_MEM_BIST_LFSR_EN (defined: Galois LFSR, undefined: seed + i).
module nios_cpu_mem_bist_master #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_words,
    input  logic [31:0]       seed,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              error,
    nios_cpu_mem_bist_master_if.master bus
);
    import nios_cpu_mem_bist_pkg::*;
    state_t                  state;
    op_t                     op_q;
    logic [15:0]             n_q, idx, n_clamp;
    logic [2:0]              dcnt;
    logic                    accept, stop, adv, cmp_fail;
    logic [DATA_W-1:0]       pat, pat_nxt;
    logic [READ_LATENCY-1:0] pv;
    logic [DATA_W-1:0]       pe [READ_LATENCY];
    logic [ADDR_W-1:0]       pa [READ_LATENCY];

    // Length clamp, run-ending condition and read-back compare
    always_comb begin
        n_clamp  = (num_words > 16'(MAX_WORDS)) ? 16'(MAX_WORDS) : num_words;
        accept   = (state == S_IDLE) && start;
        stop     = (state == S_RUN) && (abort || idx == n_q - 16'd1);
        adv      = (state == S_RUN) && !stop;
        cmp_fail = pv[READ_LATENCY-1] && (bus.m_readdata != pe[READ_LATENCY-1]);
    end

    assign error = err_count != '0;

    nios_cpu_mem_bist_patgen u_patgen (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .step  (adv),
        .seed  (seed),
        .value (pat),
        .nxt   (pat_nxt)
    );

    // Expected word and address travel with each read until its data returns
    always_ff @(posedge clk) begin
        pv[0] <= !reset && bus.m_chipselect && !bus.m_write;
        pe[0] <= pat;
        pa[0] <= bus.m_address;
        for (int j = 1; j < READ_LATENCY; j++) begin
            pv[j] <= !reset && pv[j-1];
            pe[j] <= pe[j-1];
            pa[j] <= pa[j-1];
        end
    end

    // Command sequencing, registered bus outputs and result bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            op_q             <= OP_FILL;
            n_q              <= '0;
            idx              <= '0;
            dcnt             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            aborted          <= 1'b0;
            err_count        <= '0;
            first_err_addr   <= '0;
            bus.m_address    <= '0;
            bus.m_byteenable <= '0;
            bus.m_chipselect <= 1'b0;
            bus.m_write      <= 1'b0;
            bus.m_writedata  <= '0;
        end else begin
            done <= 1'b0;
            if (cmp_fail) begin
                err_count <= err_count + {15'd0, err_count != 16'hFFFF};
                if (err_count == '0) first_err_addr <= pa[READ_LATENCY-1];
            end
            case (state)
                S_IDLE: if (start) begin
                    op_q           <= op_t'(op);
                    n_q            <= n_clamp;
                    idx            <= '0;
                    aborted        <= 1'b0;
                    err_count      <= '0;
                    first_err_addr <= '0;
                    if (n_clamp == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state            <= S_RUN;
                        busy             <= 1'b1;
                        bus.m_address    <= base_addr;
                        bus.m_byteenable <= 4'hF;
                        bus.m_chipselect <= 1'b1;
                        bus.m_write      <= op_t'(op) == OP_FILL;
                        bus.m_writedata  <= (op_t'(op) == OP_FILL) ? pat_nxt : '0;
                    end
                end
                S_RUN: if (stop) begin
                    aborted          <= abort;
                    bus.m_address    <= '0;
                    bus.m_byteenable <= '0;
                    bus.m_chipselect <= 1'b0;
                    bus.m_write      <= 1'b0;
                    bus.m_writedata  <= '0;
                    if (op_q == OP_FILL) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_DRAIN;
                        dcnt  <= 3'(READ_LATENCY - 1);
                    end
                end else begin
                    idx             <= idx + 16'd1;
                    bus.m_address   <= bus.m_address + ADDR_W'(1);
                    bus.m_writedata <= (op_q == OP_FILL) ? pat_nxt : '0;
                end
                S_DRAIN: if (dcnt == '0) begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    dcnt <= dcnt - 3'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
